// File: rtl/wave_player_if.sv
`default_nettype none
// ============================================================================
//  Module      : wave_player_if
//  Description : Bundle of the host-side table write port, playback control,
//                status and the pulse_width/update strobe pair that feeds the
//                downstream pwm stage.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    wr_en / wr_addr / wr_data   : table write port (host -> player)
//    loop_len / rate_div         : playback length and extra hold cycles
//    one_shot                    : 1 = play once, 0 = loop forever
//    start / stop                : playback control
//    busy / done                 : playback status (player -> host)
//    sample_index                : index of the sample last presented
//    update / pulse_width        : duty strobe and value (player -> pwm)
//  Modports
//    master : host / testbench side
//    slave  : wave_player side
// ============================================================================
interface wave_player_if #(
    parameter int ADDR_WIDTH     = 8,
    parameter int WAVE_LEN_WIDTH = 11,
    parameter int RATE_WIDTH     = 32
);
    logic                      wr_en;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [WAVE_LEN_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH:0]       loop_len;
    logic [RATE_WIDTH-1:0]     rate_div;
    logic                      one_shot;
    logic                      start;
    logic                      stop;
    logic                      busy;
    logic                      done;
    logic [ADDR_WIDTH-1:0]     sample_index;
    logic                      update;
    logic [WAVE_LEN_WIDTH-1:0] pulse_width;

    modport master (
        output wr_en, wr_addr, wr_data, loop_len, rate_div, one_shot, start, stop,
        input  busy, done, sample_index, update, pulse_width
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, loop_len, rate_div, one_shot, start, stop,
        output busy, done, sample_index, update, pulse_width
    );
endinterface
`default_nettype wire

// File: rtl/wave_player.sv
`default_nettype none
// ============================================================================
//  Module      : wave_player
//  Description : Sample-table sequencer for the pwm stage. Holds a
//                host-writable table of duty samples and replays it at a
//                programmable rate, presenting each sample on pulse_width
//                together with a one-cycle update strobe. Supports one-shot
//                and continuous-loop playback.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in  : single clock
//    reset  in  : synchronous, active-high
//    bus    -   : wave_player_if.slave (table write, control, status, pwm feed)
//  Sequence per sample: FETCH (RAM read) -> EMIT (register output, strobe)
//  -> HOLD for rate_div cycles, giving an update period of rate_div+2.
// ============================================================================
module wave_player #(
    parameter int DEPTH          = 256,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int WAVE_LEN       = 1024,
    parameter int WAVE_LEN_WIDTH = $clog2(WAVE_LEN + 1),
    parameter int RATE_WIDTH     = 32
) (
    input  wire logic    clk,
    input  wire logic    reset,
    wave_player_if.slave bus
);

    localparam logic [WAVE_LEN_WIDTH-1:0] C_WAVE_MAX = WAVE_LEN_WIDTH'(WAVE_LEN);
    localparam logic [ADDR_WIDTH:0]       C_LEN_MAX  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]       C_LEN_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0]     C_ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [RATE_WIDTH-1:0]     C_RATE_ONE = RATE_WIDTH'(1);

    // FINISH is the extra busy cycle at the end of a one-shot run, so that
    // done lands rate_div+1 cycles after the last update.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EMIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    // ------------------------------------------------------------------
    // Sample table: synchronous write, synchronous read-first read.
    // Contents are deliberately not reset.
    // ------------------------------------------------------------------
    logic [WAVE_LEN_WIDTH-1:0] table_mem [DEPTH];
    logic [WAVE_LEN_WIDTH-1:0] rd_data;
    logic                      rd_en;

    // Latched playback configuration and sequencing counters
    logic [ADDR_WIDTH:0]       len_cfg;
    logic [RATE_WIDTH-1:0]     rate_cfg;
    logic                      one_shot_cfg;
    logic [ADDR_WIDTH-1:0]     index;
    logic [RATE_WIDTH-1:0]     hold_cnt;

    // Registered outputs
    logic                      update_out;
    logic                      done_out;
    logic [WAVE_LEN_WIDTH-1:0] pw_out;
    logic [ADDR_WIDTH-1:0]     sidx_out;

    // Control strobes from the FSM
    logic                      load_cfg;
    logic                      emit;
    logic                      hold_load;
    logic                      advance;
    logic                      idx_inc;
    logic                      idx_clear;
    logic                      finish;

    // Combinational helpers
    logic                      is_last;
    logic [ADDR_WIDTH:0]       len_clamped;
    logic [WAVE_LEN_WIDTH-1:0] rd_clamped;

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            table_mem[bus.wr_addr] <= bus.wr_data;
        end
        if (rd_en) begin
            rd_data <= table_mem[index];
        end
    end

    // Lengths beyond the table size would index past the RAM; clamp them.
    assign len_clamped = (bus.loop_len > C_LEN_MAX) ? C_LEN_MAX : bus.loop_len;

    // Duty can never exceed a full pwm period.
    assign rd_clamped  = (rd_data > C_WAVE_MAX) ? C_WAVE_MAX : rd_data;

    // len_cfg is never 0 while playing, so the subtraction cannot wrap.
    assign is_last     = ({1'b0, index} == (len_cfg - C_LEN_ONE));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state = cur_state;
        load_cfg  = 1'b0;
        rd_en     = 1'b0;
        emit      = 1'b0;
        hold_load = 1'b0;
        advance   = 1'b0;
        idx_inc   = 1'b0;
        idx_clear = 1'b0;
        finish    = 1'b0;

        case (cur_state)
            S_IDLE: begin
                if (bus.start && !bus.stop && (bus.loop_len != '0)) begin
                    load_cfg  = 1'b1;
                    nxt_state = S_FETCH;
                end
            end
            S_FETCH: begin
                rd_en     = 1'b1;
                nxt_state = S_EMIT;
            end
            S_EMIT: begin
                emit = 1'b1;
                if (rate_cfg == '0) begin
                    advance = 1'b1;
                end else begin
                    hold_load = 1'b1;
                    nxt_state = S_HOLD;
                end
            end
            S_HOLD: begin
                // hold_cnt is loaded with rate_div (>=1) in EMIT; the last
                // hold cycle is the one that sees the count at 1.
                if (hold_cnt <= C_RATE_ONE) begin
                    advance = 1'b1;
                end
            end
            S_FINISH: begin
                finish    = 1'b1;
                nxt_state = S_IDLE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase

        if (advance) begin
            if (!is_last) begin
                idx_inc   = 1'b1;
                nxt_state = S_FETCH;
            end else if (!one_shot_cfg) begin
                idx_clear = 1'b1;
                nxt_state = S_FETCH;
            end else begin
                nxt_state = S_FINISH;
            end
        end

        // Abort wins over everything else, including a strobe that would
        // otherwise be registered on this edge and a pending done.
        if (bus.stop && (cur_state != S_IDLE)) begin
            nxt_state = S_IDLE;
            emit      = 1'b0;
            finish    = 1'b0;
            hold_load = 1'b0;
            idx_inc   = 1'b0;
            idx_clear = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: config latch, index, hold counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            len_cfg      <= '0;
            rate_cfg     <= '0;
            one_shot_cfg <= 1'b0;
            index        <= '0;
            hold_cnt     <= '0;
            update_out   <= 1'b0;
            done_out     <= 1'b0;
            pw_out       <= '0;
            sidx_out     <= '0;
        end else begin
            update_out <= emit;
            done_out   <= finish;

            if (load_cfg) begin
                len_cfg      <= len_clamped;
                rate_cfg     <= bus.rate_div;
                one_shot_cfg <= bus.one_shot;
                index        <= '0;
            end else if (idx_clear) begin
                index <= '0;
            end else if (idx_inc) begin
                index <= index + C_ADDR_ONE;
            end

            if (hold_load) begin
                hold_cnt <= rate_cfg;
            end else if ((cur_state == S_HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - C_RATE_ONE;
            end

            // pulse_width/sample_index only move together with update,
            // so they stay stable between strobes and after an abort.
            if (emit) begin
                pw_out   <= rd_clamped;
                sidx_out <= index;
            end
        end
    end

    assign bus.busy         = (cur_state != S_IDLE);
    assign bus.done         = done_out;
    assign bus.update       = update_out;
    assign bus.pulse_width  = pw_out;
    assign bus.sample_index = sidx_out;

endmodule
`default_nettype wire

// File: doc/wave_player.md
# wave_player

Upstream sequencer for the `pwm` stage. It holds a host-writable table of duty-cycle samples and replays them at a programmable sample rate. For each sample it drives `pulse_width` and a one-cycle `update` strobe into `pwm`, which latches on the rising edge of `update`. It runs in either one-shot or continuous-loop mode and is the block that turns stored waveforms into PWM duty sequences.

## Interface
Parameters:
- `DEPTH`, 256: number of sample entries in the table.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: table address width.
- `WAVE_LEN`, 1024: PWM period length in pulse steps, matching the downstream `pwm`.
- `WAVE_LEN_WIDTH`, `$clog2(WAVE_LEN + 1)`: sample and `pulse_width` width.
- `RATE_WIDTH`, 32: width of `rate_div`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: table write strobe.
- `wr_addr` in `ADDR_WIDTH`: table write address.
- `wr_data` in `WAVE_LEN_WIDTH`: sample value.
- `loop_len` in `ADDR_WIDTH+1`: number of samples to play. Latched at start.
- `rate_div` in `RATE_WIDTH`: extra hold cycles per sample. Latched at start.
- `one_shot` in 1: 1 = play once and stop; 0 = loop forever. Latched at start.
- `start` in 1: begin playback. Single-cycle pulse or level; sampled only in IDLE.
- `stop` in 1: abort playback.
- `busy` out 1: playback active.
- `done` out 1: one-cycle pulse at the end of a one-shot run.
- `sample_index` out `ADDR_WIDTH`: index of the sample most recently presented.
- `update` out 1: strobe to `pwm`.
- `pulse_width` out `WAVE_LEN_WIDTH`: duty value to `pwm`.

## Operation
- Table storage:
  - Single-port-write, synchronous-read RAM; contents are not reset.
  - A write to the address being read in the same cycle returns the old data (read-first).
  - Writes are accepted in every state.
- States:
  - IDLE: `busy`=0. `start`=1 with `loop_len`≠0 latches the config, sets index to 0 and moves to FETCH. `start` with `loop_len`=0 is ignored.
  - FETCH: issue a table read at the current index, then go to EMIT.
  - EMIT: register `pulse_width` = min(data, `WAVE_LEN`), `update`=1 and `sample_index`=index. Go to HOLD with `hold_cnt`=`rate_div`; if `rate_div`=0, skip HOLD and apply the advance rule below.
  - HOLD: decrement `hold_cnt`; when it reaches 0, apply the advance rule.
- Advance rule:
  - index < latched_len−1: increment index, go to FETCH.
  - Last index, `one_shot`=0: set index to 0, go to FETCH.
  - Last index, `one_shot`=1: go to IDLE and pulse `done`.
- Length clamp: a latched `loop_len` greater than `DEPTH` is clamped to `DEPTH`.
- `stop`:
  - In any non-IDLE state, returns the block to IDLE on the next edge with no further `update` and no `done`.
  - `pulse_width` keeps its last value.
  - If `start` and `stop` are high in the same cycle, `stop` wins.
- `start` while `busy` is ignored. Config inputs may change freely during playback without effect.
- `update` is registered and high for exactly one cycle per sample. `pulse_width` is stable from its `update` cycle until the next `update`.
- Reset values: state IDLE, `busy`=0, `done`=0, `update`=0, `pulse_width`=0, `sample_index`=0, `hold_cnt`=0. Reset mid-playback aborts immediately with no `done`.

## Timing
- With `start` high in cycle 0:
  - `busy`=1 from cycle 1.
  - First `update`=1 in cycle 3, with `pulse_width`=sample[0].
- `update` period is exactly `rate_div`+2 cycles. `update` is never high in two consecutive cycles, so every strobe is a rising edge for `pwm`.
- Loop wrap from sample `loop_len`−1 to sample 0 keeps the same `rate_div`+2 spacing; there is no gap.
- One-shot end: if the last `update` is in cycle U, then `done`=1 and `busy`=0 in cycle U+`rate_div`+1, and `done` drops the next cycle.
- After `stop` is sampled in cycle S: `busy`=0 in cycle S+1, and `update` is never high after cycle S.
- Clamp is combinational on the read data before the output register; `pulse_width` never exceeds `WAVE_LEN`.

## Test plan
- Write samples {0,256,512,1023} at addresses 0–3; `loop_len`=4, `rate_div`=5, `one_shot`=1, pulse `start` in cycle 0:
  - `update` in cycles 3, 10, 17, 24 with those values.
  - `done` in cycle 30.
  - `busy` high in cycles 1–29.
- Same table, `one_shot`=0, `rate_div`=0: `update` every 2 cycles, repeating 0,256,512,1023,0,… indefinitely with no gap at the wrap.
- Sample value 2000 with `WAVE_LEN`=1024: `pulse_width`=1024. `loop_len`=300 with `DEPTH`=256: the index wraps after 255.
- Assert `stop` in the cycle of the second `update` during a loop run:
  - No further `update`.
  - `busy`=0 next cycle.
  - No `done`.
  - `pulse_width` holds 256.
- `start` with `loop_len`=0: `busy` stays 0. `start`+`stop` in the same cycle: stays IDLE. `start` while busy: sequence unaffected.
- Assert `reset` mid-HOLD: all outputs return to reset values next cycle. Chain into `pwm` and check its output duty follows each sample.
